// File: rtl/burrito_control_if.sv
// Instruction-memory fetch port for the Burrito sequencer: req/addr out, ack/data back.
// The master holds imem_req and imem_addr steady until imem_ack; data is valid with ack.
interface burrito_control_if #(
   parameter int AW = 8
) ();
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [19:0]   imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/burrito_control.sv
// Burrito instruction sequencer: fetches 20-bit words, decodes them into we/op/d1/d2/rd
// and presents each instruction to the register-bank/ALU datapath for one EXEC cycle.
module burrito_control #(
   parameter int AW    = 8,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   burrito_control_if.master   imem,
   output logic                we,
   output logic [3:0]          op,
   output logic [4:0]          d1,
   output logic [4:0]          d2,
   output logic [4:0]          rd,
   output logic [AW-1:0]       pc,
   output logic                busy,
   output logic                halted,
   output logic [CNT_W-1:0]    retired
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      HALT
   } state_t;

   state_t state;

   // The instruction register is split: op/rd/d1/d2 live directly in the output
   // registers, so only the write-enable bit needs separate storage.
   logic ir_we;
   logic ir_halt;

   assign ir_halt        = (op == 4'hF) && !ir_we;
   assign imem.imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ir_we         <= 1'b0;
         pc            <= '0;
         retired       <= '0;
         imem.imem_req <= 1'b0;
         we            <= 1'b0;
         busy          <= 1'b0;
         halted        <= 1'b0;
         op            <= '0;
         d1            <= '0;
         d2            <= '0;
         rd            <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state         <= FETCH;
                  pc            <= '0;
                  imem.imem_req <= 1'b1;
                  busy          <= 1'b1;
               end
            end
            FETCH: begin
               if (imem.imem_ack) begin
                  state            <= DECODE;
                  {op, rd, d1, d2} <= imem.imem_data[19:1];
                  ir_we            <= imem.imem_data[0];
                  imem.imem_req    <= 1'b0;
               end
            end
            DECODE: begin
               if (ir_halt) begin
                  state  <= HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  state <= EXEC;
                  we    <= ir_we;
               end
            end
            EXEC: begin
               state         <= FETCH;
               we            <= 1'b0;
               pc            <= pc + 1'b1;
               imem.imem_req <= 1'b1;
               if (retired != '1) begin
                  retired <= retired + 1'b1;
               end
            end
            HALT: begin
               if (start) begin
                  state         <= FETCH;
                  pc            <= '0;
                  retired       <= '0;
                  halted        <= 1'b0;
                  busy          <= 1'b1;
                  imem.imem_req <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burrito_control.sv
// Directed bench for burrito_control: an AW=8 instance with a programmable memory
// model and an AW=2 instance fed an endless NOP stream for pc wrap.
module tb_burrito_control;

   logic clk;
   logic rst_n;
   logic a_start;
   logic b_start;

   int checks;
   int errors;

   burrito_control_if #(.AW(8)) a_if ();
   burrito_control_if #(.AW(2)) b_if ();

   logic        a_we, a_busy, a_halted;
   logic [3:0]  a_op;
   logic [4:0]  a_d1, a_d2, a_rd;
   logic [7:0]  a_pc;
   logic [15:0] a_retired;

   logic        b_we, b_busy, b_halted;
   logic [3:0]  b_op;
   logic [4:0]  b_d1, b_d2, b_rd;
   logic [1:0]  b_pc;
   logic [15:0] b_retired;

   burrito_control #(.AW(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .imem(a_if.master),
      .we(a_we), .op(a_op), .d1(a_d1), .d2(a_d2), .rd(a_rd), .pc(a_pc),
      .busy(a_busy), .halted(a_halted), .retired(a_retired)
   );

   burrito_control #(.AW(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .imem(b_if.master),
      .we(b_we), .op(b_op), .d1(b_d1), .d2(b_d2), .rd(b_rd), .pc(b_pc),
      .busy(b_busy), .halted(b_halted), .retired(b_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model for dut_a: ack after ack_delay waiting cycles, junk data before that.
   logic [19:0] prog [0:255];
   int          ack_delay;
   int          wait_cnt;
   logic        stray_ack;

   initial begin
      a_if.imem_ack  = 1'b0;
      a_if.imem_data = '0;
      wait_cnt       = 0;
      forever begin
         @(negedge clk);
         if (a_if.imem_req) begin
            if (wait_cnt >= ack_delay) begin
               a_if.imem_ack  = 1'b1;
               a_if.imem_data = prog[a_if.imem_addr];
            end else begin
               a_if.imem_ack  = 1'b0;
               a_if.imem_data = wait_cnt[0] ? 20'h5A5A5 : 20'hA5A5A;
            end
            wait_cnt++;
         end else begin
            a_if.imem_ack  = stray_ack;
            a_if.imem_data = 20'h12345;
            wait_cnt       = 0;
         end
      end
   end

   // dut_b memory: always acks immediately with a non-writing NOP.
   initial begin
      b_if.imem_ack  = 1'b0;
      b_if.imem_data = '0;
      forever begin
         @(negedge clk);
         b_if.imem_ack  = b_if.imem_req;
         b_if.imem_data = {4'h1, 5'd3, 5'd4, 5'd5, 1'b0};
      end
   end

   int we_cycles, we_run, we_max, req_cycles, b_we_cycles;

   initial begin
      we_cycles = 0; we_run = 0; we_max = 0; req_cycles = 0; b_we_cycles = 0;
      forever begin
         @(posedge clk);
         #1;
         if (a_we) begin
            we_cycles++;
            we_run++;
            if (we_run > we_max) we_max = we_run;
         end else begin
            we_run = 0;
         end
         if (a_if.imem_req) req_cycles++;
         if (b_we) b_we_cycles++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_halted(input string name);
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (a_halted) break;
      end
      checks++;
      if (a_halted !== 1'b1) begin
         errors++;
         $display("FAIL %s halt_wait: halted=%b expected 1", name, a_halted);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
      ack_delay = 0; stray_ack = 1'b0;
      #12;
      checks++;
      if ({a_if.imem_req, a_we, a_busy, a_halted, a_op, a_d1, a_d2, a_rd, a_pc, a_retired} !== '0) begin
         errors++;
         $display("FAIL reset_a: outputs=%h expected 0",
                  {a_if.imem_req, a_we, a_busy, a_halted, a_op, a_d1, a_d2, a_rd, a_pc, a_retired});
      end
      checks++;
      if ({b_if.imem_req, b_we, b_busy, b_halted, b_pc, b_retired} !== '0) begin
         errors++;
         $display("FAIL reset_b: outputs=%h expected 0",
                  {b_if.imem_req, b_we, b_busy, b_halted, b_pc, b_retired});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      // 20'h21085: op=2, rd=2, d1=2, d2=2, we=1
      prog[0] = 20'h21085;
      prog[1] = 20'hF0000;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      checks++;
      if ({a_if.imem_req, a_if.imem_addr, a_busy, a_we} !== {1'b1, 8'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_fetch: req/addr/busy/we=%b/%h/%b/%b expected 1/00/1/0",
                  a_if.imem_req, a_if.imem_addr, a_busy, a_we);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_if.imem_req, a_we, a_op, a_rd, a_d1, a_d2} !== {1'b0, 1'b0, 4'd2, 5'd2, 5'd2, 5'd2}) begin
         errors++;
         $display("FAIL single_decode: req=%b we=%b op=%h rd=%0d d1=%0d d2=%0d expected 0 0 2 2 2 2",
                  a_if.imem_req, a_we, a_op, a_rd, a_d1, a_d2);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_we, a_op, a_rd, a_pc} !== {1'b1, 4'd2, 5'd2, 8'd0}) begin
         errors++;
         $display("FAIL single_exec: we=%b op=%h rd=%0d pc=%0d expected 1 2 2 0", a_we, a_op, a_rd, a_pc);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_we, a_pc, a_retired, a_if.imem_req} !== {1'b0, 8'd1, 16'd1, 1'b1}) begin
         errors++;
         $display("FAIL single_next: we=%b pc=%0d retired=%0d req=%b expected 0 1 1 1",
                  a_we, a_pc, a_retired, a_if.imem_req);
      end
      wait_halted("single");
      checks++;
      if ({a_pc, a_retired, a_busy} !== {8'd1, 16'd1, 1'b0}) begin
         errors++;
         $display("FAIL single_halt: pc=%0d retired=%0d busy=%b expected 1 1 0", a_pc, a_retired, a_busy);
      end
   endtask

   task automatic test_program;
      prog[0] = {4'h1, 5'd1, 5'd2, 5'd3, 1'b1};
      prog[1] = {4'h3, 5'd4, 5'd5, 5'd6, 1'b1};
      prog[2] = {4'hF, 5'd7, 5'd8, 5'd9, 1'b1};
      prog[3] = 20'hF0000;
      @(negedge clk);
      we_cycles = 0; we_max = 0;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      checks++;
      if ({a_pc, a_retired, a_halted, a_if.imem_req} !== {8'd0, 16'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL restart: pc=%0d retired=%0d halted=%b req=%b expected 0 0 0 1",
                  a_pc, a_retired, a_halted, a_if.imem_req);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      wait_halted("program");
      checks++;
      if ({a_pc, a_retired, a_op} !== {8'd3, 16'd3, 4'hF}) begin
         errors++;
         $display("FAIL program_end: pc=%0d retired=%0d op=%h expected 3 3 F", a_pc, a_retired, a_op);
      end
      checks++;
      if (we_cycles != 3 || we_max != 1) begin
         errors++;
         $display("FAIL program_we: pulses=%0d longest=%0d expected 3 1", we_cycles, we_max);
      end
      @(negedge clk);
      req_cycles = 0;
      repeat (5) @(posedge clk);
      #2;
      checks++;
      if (req_cycles != 0 || a_halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_idle: req_cycles=%0d halted=%b expected 0 1", req_cycles, a_halted);
      end
   endtask

   task automatic test_delayed_ack;
      prog[0] = {4'h3, 5'd5, 5'd9, 5'd17, 1'b1};
      prog[1] = 20'hF0000;
      ack_delay = 5;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({a_if.imem_req, a_if.imem_addr, a_busy} !== {1'b1, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL delay_hold[%0d]: req/addr/busy=%b/%h/%b expected 1/00/1",
                     i, a_if.imem_req, a_if.imem_addr, a_busy);
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 20; i++) begin
         if (!a_if.imem_req) break;
         @(posedge clk); #1;
      end
      checks++;
      if ({a_if.imem_req, a_op, a_rd, a_d1, a_d2} !== {1'b0, 4'd3, 5'd5, 5'd9, 5'd17}) begin
         errors++;
         $display("FAIL delay_capture: req=%b op=%h rd=%0d d1=%0d d2=%0d expected 0 3 5 9 17",
                  a_if.imem_req, a_op, a_rd, a_d1, a_d2);
      end
      wait_halted("delay");
      checks++;
      if ({a_pc, a_retired} !== {8'd1, 16'd1}) begin
         errors++;
         $display("FAIL delay_end: pc=%0d retired=%0d expected 1 1", a_pc, a_retired);
      end
      ack_delay = 0;
   endtask

   task automatic test_op_f;
      prog[0] = 20'hF0001;
      prog[1] = 20'hF0000;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({a_op, a_halted, a_we} !== {4'hF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL opf_decode: op=%h halted=%b we=%b expected F 0 0", a_op, a_halted, a_we);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_we, a_halted, a_busy} !== {1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL opf_exec: we=%b halted=%b busy=%b expected 1 0 1", a_we, a_halted, a_busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_pc, a_if.imem_req, a_halted} !== {8'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL opf_next: pc=%0d req=%b halted=%b expected 1 1 0", a_pc, a_if.imem_req, a_halted);
      end
      wait_halted("opf");
   endtask

   task automatic test_wrap;
      @(negedge clk);
      b_we_cycles = 0;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({b_if.imem_req, b_pc, b_retired} !== {1'b1, 2'(i), 16'(i)}) begin
            errors++;
            $display("FAIL wrap_fetch[%0d]: req=%b pc=%0d retired=%0d expected 1 %0d %0d",
                     i, b_if.imem_req, b_pc, b_retired, i % 4, i);
         end
         @(posedge clk);
         @(posedge clk); #1;
         checks++;
         if (b_we !== 1'b0) begin
            errors++;
            $display("FAIL wrap_we[%0d]: we=%b expected 0", i, b_we);
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({b_pc, b_retired} !== {2'd1, 16'd5}) begin
         errors++;
         $display("FAIL wrap_end: pc=%0d retired=%0d expected 1 5", b_pc, b_retired);
      end
      checks++;
      if (b_we_cycles != 0) begin
         errors++;
         $display("FAIL wrap_we_total: we_cycles=%0d expected 0", b_we_cycles);
      end
   endtask

   task automatic test_reset_mid;
      ack_delay = 3;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_if.imem_req, a_busy, a_pc, a_retired} !== {1'b0, 1'b0, 8'd0, 16'd0}) begin
         errors++;
         $display("FAIL rst_fetch: req=%b busy=%b pc=%0d retired=%0d expected 0 0 0 0",
                  a_if.imem_req, a_busy, a_pc, a_retired);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({a_if.imem_req, a_we, a_busy, a_halted, a_op, a_d1, a_d2, a_rd, a_pc, a_retired} !== '0) begin
         errors++;
         $display("FAIL rst_idle: outputs=%h expected 0",
                  {a_if.imem_req, a_we, a_busy, a_halted, a_op, a_d1, a_d2, a_rd, a_pc, a_retired});
      end
      ack_delay = 0;
      prog[0] = {4'h5, 5'd1, 5'd1, 5'd1, 1'b1};
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (a_we !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec_pre: we=%b expected 1", a_we);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_we, a_op, a_busy} !== {1'b0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL rst_exec: we=%b op=%h busy=%b expected 0 0 0", a_we, a_op, a_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stray_ack = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({a_if.imem_req, a_busy, a_op, a_pc} !== {1'b0, 1'b0, 4'd0, 8'd0}) begin
         errors++;
         $display("FAIL stray_ack: req=%b busy=%b op=%h pc=%0d expected 0 0 0 0",
                  a_if.imem_req, a_busy, a_op, a_pc);
      end
      stray_ack = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) prog[i] = 20'hF0000;
      test_reset();
      test_single();
      test_program();
      test_delayed_ack();
      test_op_f();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
